id_exe_reg: RTL and testbench

- Pipeline register between the decode stage (control unit plus register file read) and the execute stage of the 5-stage MIPS core.
- Latches decoded control (exe_cmd, mem_r_en, mem_w_en, wb_en, br_type) and datapath operands every cycle.
- Supports stall (freeze) and bubble insertion (flush).
- Keeps a saturating bubble counter for performance monitoring.

---
 rtl/id_exe_reg.sv | 100 ++++++++++
 tb/tb_id_exe_reg.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - decode/execute pipeline register with freeze, flush and a saturating bubble counter
module id_exe_reg #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_LEN      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic [3:0]              exe_cmd_in,
    input  logic                    mem_r_en_in,
    input  logic                    mem_w_en_in,
    input  logic                    wb_en_in,
    input  logic [1:0]              br_type_in,
    input  logic [WORD_LEN-1:0]     pc_in,
    input  logic [WORD_LEN-1:0]     val1_in,
    input  logic [WORD_LEN-1:0]     val2_in,
    input  logic [WORD_LEN-1:0]     st_val_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [REG_ADDR_LEN-1:0] src1_in,
    input  logic [REG_ADDR_LEN-1:0] src2_in,
    output logic [3:0]              exe_cmd,
    output logic                    mem_r_en,
    output logic                    mem_w_en,
    output logic                    wb_en,
    output logic [1:0]              br_type,
    output logic [WORD_LEN-1:0]     pc,
    output logic [WORD_LEN-1:0]     val1,
    output logic [WORD_LEN-1:0]     val2,
    output logic [WORD_LEN-1:0]     st_val,
    output logic [REG_ADDR_LEN-1:0] dest,
    output logic [REG_ADDR_LEN-1:0] src1,
    output logic [REG_ADDR_LEN-1:0] src2,
    output logic                    valid,
    output logic [CNT_LEN-1:0]      bubble_cnt
);

    // Counter is at its ceiling; further bubbles must not wrap it back to zero
    logic cnt_full;
    assign cnt_full = (bubble_cnt == {CNT_LEN{1'b1}});

    // Stage contents: flush loads an all-zero bubble (wrong-path kill beats a stall),
    // freeze holds everything, otherwise capture the decoded instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_cmd  <= '0;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            wb_en    <= 1'b0;
            br_type  <= '0;
            pc       <= '0;
            val1     <= '0;
            val2     <= '0;
            st_val   <= '0;
            dest     <= '0;
            src1     <= '0;
            src2     <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            exe_cmd  <= '0;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            wb_en    <= 1'b0;
            br_type  <= '0;
            pc       <= '0;
            val1     <= '0;
            val2     <= '0;
            st_val   <= '0;
            dest     <= '0;
            src1     <= '0;
            src2     <= '0;
            valid    <= 1'b0;
        end else if (!freeze) begin
            exe_cmd  <= exe_cmd_in;
            mem_r_en <= mem_r_en_in;
            mem_w_en <= mem_w_en_in;
            wb_en    <= wb_en_in;
            br_type  <= br_type_in;
            pc       <= pc_in;
            val1     <= val1_in;
            val2     <= val2_in;
            st_val   <= st_val_in;
            dest     <= dest_in;
            src1     <= src1_in;
            src2     <= src2_in;
            valid    <= 1'b1;
        end
    end

    // Count each edge that inserts a bubble or holds a stall; flush+freeze counts once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if ((flush || freeze) && !cnt_full) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - directed self-checking bench for id_exe_reg
module tb_id_exe_reg;

    localparam int WL = 32;
    localparam int RL = 5;
    localparam int CL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          flush;
    logic [3:0]    exe_cmd_in;
    logic          mem_r_en_in;
    logic          mem_w_en_in;
    logic          wb_en_in;
    logic [1:0]    br_type_in;
    logic [WL-1:0] pc_in;
    logic [WL-1:0] val1_in;
    logic [WL-1:0] val2_in;
    logic [WL-1:0] st_val_in;
    logic [RL-1:0] dest_in;
    logic [RL-1:0] src1_in;
    logic [RL-1:0] src2_in;
    logic [3:0]    exe_cmd;
    logic          mem_r_en;
    logic          mem_w_en;
    logic          wb_en;
    logic [1:0]    br_type;
    logic [WL-1:0] pc;
    logic [WL-1:0] val1;
    logic [WL-1:0] val2;
    logic [WL-1:0] st_val;
    logic [RL-1:0] dest;
    logic [RL-1:0] src1;
    logic [RL-1:0] src2;
    logic          valid;
    logic [CL-1:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    id_exe_reg #(.WORD_LEN(WL), .REG_ADDR_LEN(RL), .CNT_LEN(CL)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .exe_cmd_in(exe_cmd_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .wb_en_in(wb_en_in), .br_type_in(br_type_in), .pc_in(pc_in),
        .val1_in(val1_in), .val2_in(val2_in), .st_val_in(st_val_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .exe_cmd(exe_cmd), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
        .br_type(br_type), .pc(pc), .val1(val1), .val2(val2), .st_val(st_val),
        .dest(dest), .src1(src1), .src2(src2), .valid(valid), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic mr, input logic mw, input logic wb,
                         input logic [1:0] br, input logic [31:0] p, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] sv, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2);
        exe_cmd_in = cmd; mem_r_en_in = mr; mem_w_en_in = mw; wb_en_in = wb;
        br_type_in = br;  pc_in = p; val1_in = v1; val2_in = v2; st_val_in = sv;
        dest_in = d; src1_in = s1; src2_in = s2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ctrl"}, {27'd0, exe_cmd, mem_r_en, mem_w_en, wb_en, br_type}, 32'd0);
        check({tag, ".pc"}, pc, 32'd0);
        check({tag, ".val1"}, val1, 32'd0);
        check({tag, ".val2"}, val2, 32'd0);
        check({tag, ".st_val"}, st_val, 32'd0);
        check({tag, ".regs"}, {17'd0, dest, src1, src2}, 32'd0);
        check({tag, ".valid"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0;
        drive(4'h0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_all_zero("reset");
        check("reset.cnt", {28'd0, bubble_cnt}, 32'd0);
        rst = 1'b0;

        // ADDI r3 = r1 + (-2)
        drive(4'h0, 0, 0, 1, 2'b00, 32'h10, 32'h5, 32'hFFFF_FFFE, 32'h0, 5'd3, 5'd1, 5'd0);
        step();
        check("addi.cmd", {28'd0, exe_cmd}, 32'h0);
        check("addi.wb", {31'd0, wb_en}, 32'd1);
        check("addi.pc", pc, 32'h10);
        check("addi.val1", val1, 32'h5);
        check("addi.val2", val2, 32'hFFFF_FFFE);
        check("addi.dest", {27'd0, dest}, 32'd3);
        check("addi.src1", {27'd0, src1}, 32'd1);
        check("addi.valid", {31'd0, valid}, 32'd1);
        check("addi.cnt", {28'd0, bubble_cnt}, 32'd0);

        // SUB r7, then freeze 3 edges while an OR waits at the inputs
        drive(4'h2, 0, 0, 1, 2'b00, 32'h14, 32'h9, 32'h2, 32'h2, 5'd7, 5'd4, 5'd5);
        step();
        check("sub.cmd", {28'd0, exe_cmd}, 32'h2);
        drive(4'h5, 0, 0, 1, 2'b00, 32'h18, 32'hF0, 32'h0F, 32'h0F, 5'd9, 5'd6, 5'd8);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz.cmd", {28'd0, exe_cmd}, 32'h2);
            check("frz.dest", {27'd0, dest}, 32'd7);
            check("frz.val1", val1, 32'h9);
            check("frz.valid", {31'd0, valid}, 32'd1);
            check("frz.cnt", {28'd0, bubble_cnt}, i + 1);
        end
        freeze = 1'b0;
        step();
        check("or.cmd", {28'd0, exe_cmd}, 32'h5);
        check("or.dest", {27'd0, dest}, 32'd9);
        check("or.src2", {27'd0, src2}, 32'd8);
        check("or.cnt", {28'd0, bubble_cnt}, 32'd3);

        // ST then flush+freeze together: bubble, counted once
        drive(4'h0, 0, 1, 0, 2'b00, 32'h1C, 32'h100, 32'h4, 32'hDEAD, 5'd0, 5'd2, 5'd3);
        step();
        check("st.mem_w", {31'd0, mem_w_en}, 32'd1);
        check("st.st_val", st_val, 32'hDEAD);
        freeze = 1'b1; flush = 1'b1;
        step();
        check_all_zero("flush");
        check("flush.cnt", {28'd0, bubble_cnt}, 32'd4);
        freeze = 1'b0; flush = 1'b0;

        // BNE pass-through
        drive(4'h1, 0, 0, 0, 2'b10, 32'h20, 32'h4, 32'h4, 32'h4, 5'd0, 5'd10, 5'd11);
        step();
        check("bne.br", {30'd0, br_type}, 32'h2);
        check("bne.wb", {31'd0, wb_en}, 32'd0);
        check("bne.valid", {31'd0, valid}, 32'd1);
        check("bne.val2", val2, 32'h4);
        check("bne.cnt", {28'd0, bubble_cnt}, 32'd4);

        // Asynchronous reset mid-cycle, with a stall pending
        freeze = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        check("arst.cnt", {28'd0, bubble_cnt}, 32'd0);
        step();
        check("arst_hold.valid", {31'd0, valid}, 32'd0);
        check("arst_hold.cnt", {28'd0, bubble_cnt}, 32'd0);
        #2;
        rst = 1'b0;
        freeze = 1'b0;
        step();
        check("post_rst.br", {30'd0, br_type}, 32'h2);
        check("post_rst.valid", {31'd0, valid}, 32'd1);
        check("post_rst.cnt", {28'd0, bubble_cnt}, 32'd0);

        // Saturation at 2^4-1
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("sat.cnt", {28'd0, bubble_cnt}, 32'd15);
        freeze = 1'b0;
        drive(4'h3, 1, 0, 1, 2'b00, 32'h40, 32'h7, 32'h8, 32'h0, 5'd12, 5'd13, 5'd14);
        step();
        check("sat_cap.cnt", {28'd0, bubble_cnt}, 32'd15);
        check("sat_cap.mem_r", {31'd0, mem_r_en}, 32'd1);
        check("sat_cap.dest", {27'd0, dest}, 32'd12);
        flush = 1'b1;
        step();
        check("sat_flush.cnt", {28'd0, bubble_cnt}, 32'd15);
        check("sat_flush.valid", {31'd0, valid}, 32'd0);
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
